// File: rtl/p09_pkg.sv
// p09_pkg: shared state type and byte width for the sprite loader
package p09_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} loader_state_t;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/p09_byte_serializer.sv
// p09_byte_serializer: one-byte buffer emitting its bits MSB-first, with bit count and empty flag
module p09_byte_serializer
  import p09_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_msb,
  output logic [3:0]        o_cnt,
  output logic              o_empty
);
  logic [BYTE_W-1:0] r_buf;
  logic [3:0]        r_cnt;
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_buf <= i_data;
      r_cnt <= 4'(BYTE_W);
    end else if (i_shift && r_cnt != 4'd0) begin
      r_buf <= {r_buf[BYTE_W-2:0], 1'b0};
      r_cnt <= r_cnt - 4'd1;
    end
  end
  assign o_msb   = r_buf[BYTE_W-1];
  assign o_cnt   = r_cnt;
  assign o_empty = r_cnt == 4'd0;
endmodule

// File: rtl/p09_sprite_loader.sv
// p09_sprite_loader: streams host bytes MSB-first into the sprite shift register
// while the display leaves the register alone.
module p09_sprite_loader
  import p09_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       write_window,
  input  logic       display_shift,
  output logic       sprite_wr_bit,
  output logic       sprite_wr_en,
  output logic       busy,
  output logic       done
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  loader_state_t r_state;
  logic [CW-1:0] r_written;
  logic          w_msb;
  logic          w_empty;
  logic [3:0]    w_cnt;
  logic          w_load;
  // a restart in a FETCH cycle must not swallow a byte belonging to the new load
  assign byte_ready    = r_state == FETCH && !start;
  assign w_load        = byte_ready && byte_valid;
  assign sprite_wr_en  = r_state == SHIFT && write_window && !display_shift && !w_empty;
  assign sprite_wr_bit = w_msb;
  assign busy          = r_state != IDLE;
  assign done          = r_state == DONE;
  p09_byte_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_clear (start),
    .i_load  (w_load),
    .i_data  (byte_data),
    .i_shift (sprite_wr_en),
    .o_msb   (w_msb),
    .o_cnt   (w_cnt),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_written <= '0;
    end else if (start) begin
      r_state   <= FETCH;
      r_written <= '0;
    end else begin
      unique case (r_state)
        FETCH: if (byte_valid) r_state <= SHIFT;
        SHIFT: if (sprite_wr_en) begin
          r_written <= r_written + 1'b1;
          r_state   <= r_written == CW'(TOTAL - 1) ? DONE : w_cnt == 4'd1 ? FETCH : SHIFT;
        end
        DONE:  r_state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule
